// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit: opcodes, flush FSM states,
// and the branch-condition decode helpers used at resolve.
package branch_predict_unit_pkg;

  localparam int unsigned OPCODE_W    = 5;
  localparam int unsigned FLUSH_CNT_W = 3;

  localparam logic [OPCODE_W-1:0] OP_BEQZ = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_BNEZ = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_BLTZ = 5'b01110;
  localparam logic [OPCODE_W-1:0] OP_BGEZ = 5'b01111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

  // True for the four conditional branch opcodes.
  function automatic logic is_branch(input logic [OPCODE_W-1:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Actual outcome of a branch from the operand flags; 0 for non-branches.
  function automatic logic branch_outcome(input logic [OPCODE_W-1:0] op,
                                          input logic pos,
                                          input logic neg,
                                          input logic zero);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_BEQZ: taken = zero;
      OP_BNEZ: taken = pos | neg;
      OP_BLTZ: taken = neg;
      OP_BGEZ: taken = pos | zero;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// sat_counter: next-value logic for an up/down saturating counter.
// Ports:
//   cnt        - current counter value
//   en         - step the counter this cycle
//   up         - 1 = increment, 0 = decrement
//   cnt_next_c - next value, clamped to 0 .. all-ones (equals cnt when !en)
module sat_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] cnt_next_c
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_MIN = '0;

  // Step in the requested direction unless already at that end of the range.
  always_comb begin
    cnt_next_c = cnt;
    if (en) begin
      if (up) begin
        if (cnt != CNT_MAX) cnt_next_c = cnt + WIDTH'(1);
      end else begin
        if (cnt != CNT_MIN) cnt_next_c = cnt - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: saturating-counter branch predictor with resolve,
// mispredict detection, multi-cycle flush and performance counters.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   fetch_pc / pred_taken - fetch-side lookup (combinational table read)
//   resolve_*             - execute-side branch instruction and carried prediction
//   pos/neg/zero_flag     - operand condition flags
//   branch_taken          - actual outcome (combinational)
//   mispredict, flush     - registered mispredict pulse and pipeline flush
//   branch_count, mispredict_count - saturating perf counters
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned IDX_BITS     = 4,
  parameter int unsigned CTR_BITS     = 2,
  parameter int unsigned PC_WIDTH     = 16,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned PERF_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   fetch_pc,
  output logic                  pred_taken,
  input  logic                  resolve_valid,
  input  logic [PC_WIDTH-1:0]   resolve_pc,
  input  logic [4:0]            resolve_opcode,
  input  logic                  resolve_pred,
  input  logic                  pos_flag,
  input  logic                  neg_flag,
  input  logic                  zero_flag,
  output logic                  branch_taken,
  output logic                  mispredict,
  output logic                  flush,
  output logic [PERF_WIDTH-1:0] branch_count,
  output logic [PERF_WIDTH-1:0] mispredict_count
);

  localparam int unsigned NUM_ENTRIES = 1 << IDX_BITS;
  // Weakly not-taken: just below the taken threshold (0 for 1-bit counters).
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0]    bht_q [NUM_ENTRIES];
  logic [CTR_BITS-1:0]    bht_d [NUM_ENTRIES];
  logic [CTR_BITS-1:0]    entry_next_c;

  flush_state_e           state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic                   flush_q, flush_d;
  logic                   mispredict_q, mispredict_d;
  logic [PERF_WIDTH-1:0]  branch_count_q, branch_count_d;
  logic [PERF_WIDTH-1:0]  mispredict_count_q, mispredict_count_d;

  logic [IDX_BITS-1:0]    fetch_idx;
  logic [IDX_BITS-1:0]    resolve_idx;
  logic                   resolve_event_c;
  logic                   unused_pc_bits;

  // 2-byte instructions: bit 0 never selects an entry.
  assign fetch_idx   = fetch_pc[IDX_BITS:1];
  assign resolve_idx = resolve_pc[IDX_BITS:1];
  assign unused_pc_bits = ^{fetch_pc[PC_WIDTH-1:IDX_BITS+1], fetch_pc[0],
                            resolve_pc[PC_WIDTH-1:IDX_BITS+1], resolve_pc[0]};

  // Pre-edge table read; a same-cycle update is intentionally not forwarded.
  assign pred_taken = bht_q[fetch_idx][CTR_BITS-1];

  // Resolve decode; wrong-path resolves during a flush are dropped.
  always_comb begin
    branch_taken    = branch_outcome(resolve_opcode, pos_flag, neg_flag, zero_flag);
    resolve_event_c = resolve_valid & is_branch(resolve_opcode) & ~flush_q;
    mispredict_d    = resolve_event_c & (branch_taken != resolve_pred);
  end

  sat_counter #(.WIDTH(CTR_BITS)) u_entry_ctr (
    .cnt        (bht_q[resolve_idx]),
    .en         (resolve_event_c),
    .up         (branch_taken),
    .cnt_next_c (entry_next_c)
  );

  sat_counter #(.WIDTH(PERF_WIDTH)) u_branch_ctr (
    .cnt        (branch_count_q),
    .en         (resolve_event_c),
    .up         (1'b1),
    .cnt_next_c (branch_count_d)
  );

  sat_counter #(.WIDTH(PERF_WIDTH)) u_mispredict_ctr (
    .cnt        (mispredict_count_q),
    .en         (mispredict_d),
    .up         (1'b1),
    .cnt_next_c (mispredict_count_d)
  );

  // Table write-back; entry_next_c equals the old value when no resolve event.
  always_comb begin
    bht_d              = bht_q;
    bht_d[resolve_idx] = entry_next_c;
  end

  // Flush FSM next-state: FLUSH_CYCLES flush cycles following a mispredict.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mispredict_d) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES);
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
          state_d     = ST_IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        flush_cnt_d = '0;
      end
    endcase
    flush_d = (state_d == ST_FLUSH);
  end

  // State registers; reset wins over any concurrent resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      bht_q              <= '{default: CTR_INIT};
      state_q            <= ST_IDLE;
      flush_cnt_q        <= '0;
      flush_q            <= 1'b0;
      mispredict_q       <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      bht_q              <= bht_d;
      state_q            <= state_d;
      flush_cnt_q        <= flush_cnt_d;
      flush_q            <= flush_d;
      mispredict_q       <= mispredict_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign mispredict       = mispredict_q;
  assign flush            = flush_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
